brq_instruction: RTL and testbench
==================================

BRQ_INSTRUCTION -- requirements
Module: brq_instruction

Interface
REQ-001 Parameter: WIDTH, default 19, data and address width of r2, r3, branch_addr, pc_next and pc.
REQ-002 Parameter: RESET_PC, default 0, value loaded into pc on reset.
REQ-003 Clocking: one clock, clk; reset rst is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  qualifies r2, r3, branch_addr and pc_next this cycle.
REQ-007 r2  input  WIDTH  first compare operand.
REQ-008 r3  input  WIDTH  second compare operand.
REQ-009 branch_addr  input  WIDTH  target PC when the branch is taken.
REQ-010 pc_next  input  WIDTH  fall-through PC when the branch is not taken.
REQ-011 pc  output  WIDTH  registered selected PC.
REQ-012 out_valid  output  1  pc/taken updated from a valid request on the previous edge.
REQ-013 taken  output  1  registered branch decision, 1 when r2 equaled r3.

Function
REQ-014 Branch-if-equal: the condition SHALL be an unsigned full-WIDTH bitwise equality of r2 and r3.
REQ-015 On a rising edge with in_valid=1 and rst=0, pc SHALL load branch_addr when r2==r3, else pc_next.
REQ-016 On the same edge, taken SHALL load the comparison result and out_valid SHALL load 1.
REQ-017 Latency is exactly one clock from inputs to pc/taken/out_valid; there is no combinational input-to-output path.
REQ-018 With in_valid=0, pc and taken SHALL hold their values and out_valid SHALL load 0.
REQ-019 Back-to-back valid requests SHALL be accepted every cycle with no stall and no backpressure.
REQ-020 branch_addr and pc_next SHALL pass through unmodified: no alignment, no offset arithmetic, no wrap handling.
REQ-021 Values with only the MSB (bit WIDTH-1) differing SHALL be treated as not equal.

Reset
REQ-022 While rst=1 at a rising edge, pc SHALL load RESET_PC and taken and out_valid SHALL load 0, regardless of in_valid.
REQ-023 A request presented in the same cycle as rst=1 SHALL be discarded; the first valid request after rst falls behaves normally.

Configuration
REQ-024 Macro BRQ_STATS_EN: when defined, the module SHALL add outputs req_count[15:0] and taken_count[15:0].
REQ-025 With BRQ_STATS_EN, req_count SHALL increment on each accepted valid request, and taken_count on each taken one.
REQ-026 With BRQ_STATS_EN, both counters SHALL saturate at 16'hFFFF and SHALL clear to 0 on rst.
REQ-027 Without BRQ_STATS_EN, neither counter nor port SHALL exist, and all other behaviour SHALL be identical.

Structure
REQ-028 Package brq_pkg SHALL hold: ADDR_W=19, RESET_PC=0, and the stats counter width STATS_W=16.
REQ-029 The module SHALL use one sub-module, brq_cmp: a combinational WIDTH-bit equality comparator whose output feeds the PC select and the taken register.

Verification
REQ-030 Test 1: rst=1 for 2 cycles, then rst=0 with in_valid=0 -> pc=0, taken=0, out_valid=0.
REQ-031 Test 2: r2=2, r3=2, branch_addr=150, pc_next=200, in_valid=1 -> next edge pc=150, taken=1, out_valid=1.
REQ-032 Test 3: r2=2, r3=3, branch_addr=150, pc_next=200, in_valid=1 -> next edge pc=200, taken=0, out_valid=1.
REQ-033 Test 4: valid request, then in_valid=0 with different operands -> pc/taken hold their values, out_valid=0.
REQ-034 Test 5: r2=19'h40000, r3=0, then r2=r3=19'h7FFFF, back-to-back -> pc=pc_next then pc=branch_addr on consecutive edges.
REQ-035 Test 6: rst=1 asserted with in_valid=1 and equal operands -> pc=0, out_valid=0. With BRQ_STATS_EN: 5 requests, 3 taken -> req_count=5, taken_count=3.

Source files
------------

// File: rtl/brq_pkg.sv
// -----------------------------------------------------------------------------
// brq_pkg
// Shared constants and helpers for the branch-if-equal PC select block.
//   ADDR_W   : default data/address width of operands and PCs
//   RESET_PC : default PC value loaded on reset
//   STATS_W  : width of the optional request/taken statistics counters
//   sat_inc  : saturating increment used by the statistics counters
// -----------------------------------------------------------------------------
package brq_pkg;

   localparam int                ADDR_W   = 19;
   localparam logic [ADDR_W-1:0] RESET_PC = '0;
   localparam int                STATS_W  = 16;

   // Counters stick at all-ones instead of wrapping back to zero.
   function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage : brq_pkg

// File: rtl/brq_cmp.sv
// -----------------------------------------------------------------------------
// brq_cmp
// Combinational WIDTH-bit unsigned equality comparator. Every bit takes part,
// so operands that differ only in the MSB compare as not equal.
// Ports:
//   a, b : input  [WIDTH-1:0] operands
//   eq   : output             1 when a and b are bitwise identical
// -----------------------------------------------------------------------------
module brq_cmp #(
   parameter int WIDTH = brq_pkg::ADDR_W
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             eq
);

   assign eq = (a == b);

endmodule : brq_cmp

// File: rtl/brq_instruction.sv
// -----------------------------------------------------------------------------
// brq_instruction
// Branch-if-equal next-PC select. On each valid request the block compares
// r2 with r3 and registers either branch_addr (equal) or pc_next (not equal)
// into pc, together with the decision in taken. One clock of latency, a new
// request is accepted every cycle, and no input reaches an output without
// passing through a register.
//
// Ports:
//   clk         : input             rising-edge clock
//   rst         : input             synchronous active-high reset
//   in_valid    : input             qualifies r2, r3, branch_addr, pc_next
//   r2, r3      : input  [WIDTH-1:0] compare operands
//   branch_addr : input  [WIDTH-1:0] target PC when taken
//   pc_next     : input  [WIDTH-1:0] fall-through PC when not taken
//   pc          : output [WIDTH-1:0] registered selected PC
//   out_valid   : output             pc/taken updated by last edge's request
//   taken       : output             registered branch decision
//   req_count   : output [15:0]      accepted requests   (BRQ_STATS_EN only)
//   taken_count : output [15:0]      taken requests      (BRQ_STATS_EN only)
//
// Build option: define BRQ_STATS_EN to add the saturating statistics counters.
// -----------------------------------------------------------------------------
module brq_instruction #(
   parameter int               WIDTH    = brq_pkg::ADDR_W,
   parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(brq_pkg::RESET_PC)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] r2,
   input  logic [WIDTH-1:0] r3,
   input  logic [WIDTH-1:0] branch_addr,
   input  logic [WIDTH-1:0] pc_next,
   output logic [WIDTH-1:0] pc,
   output logic             out_valid,
   output logic             taken
`ifdef BRQ_STATS_EN
   ,
   output logic [brq_pkg::STATS_W-1:0] req_count,
   output logic [brq_pkg::STATS_W-1:0] taken_count
`endif
);

   import brq_pkg::*;

   logic is_equal;

   brq_cmp #(
      .WIDTH (WIDTH)
   ) u_cmp (
      .a  (r2),
      .b  (r3),
      .eq (is_equal)
   );

   // NOTE: state is updated with non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         // A request arriving alongside reset is dropped, not queued.
         pc        <= RESET_PC;
         taken     <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            pc    <= is_equal ? branch_addr : pc_next;
            taken <= is_equal;
         end
      end
   end

`ifdef BRQ_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         req_count   <= '0;
         taken_count <= '0;
      end else if (in_valid) begin
         req_count <= sat_inc(req_count);
         if (is_equal) begin
            taken_count <= sat_inc(taken_count);
         end
      end
   end
`endif

endmodule : brq_instruction

// File: tb/tb_brq_instruction.sv
// -----------------------------------------------------------------------------
// tb_brq_instruction
// Self-checking bench for brq_instruction. A table of hand-derived vectors
// drives the directed cases; a reference model supplies expectations for a
// random burst and a final reset/stats sequence. Expected results go into a
// scoreboard queue when stimulus is driven and are popped after the edge.
// Compile with +define+BRQ_STATS_EN to also check the statistics counters.
// -----------------------------------------------------------------------------
module tb_brq_instruction;

   localparam int W = 19;

   typedef struct {
      logic         rst;
      logic         v;
      logic [W-1:0] r2;
      logic [W-1:0] r3;
      logic [W-1:0] ba;
      logic [W-1:0] pn;
      logic [W-1:0] pc;
      logic         tk;
      logic         ov;
   } vec_t;

   typedef struct {
      logic [W-1:0] pc;
      logic         tk;
      logic         ov;
   } exp_t;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic [W-1:0] r2;
   logic [W-1:0] r3;
   logic [W-1:0] branch_addr;
   logic [W-1:0] pc_next;
   logic [W-1:0] pc;
   logic         out_valid;
   logic         taken;
`ifdef BRQ_STATS_EN
   logic [15:0]  req_count;
   logic [15:0]  taken_count;
`endif

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic [W-1:0] m_pc;
   logic         m_tk;
   int           m_req;
   int           m_tkn;

   exp_t sb[$];

   brq_instruction #(
      .WIDTH    (W),
      .RESET_PC ('0)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .r2          (r2),
      .r3          (r3),
      .branch_addr (branch_addr),
      .pc_next     (pc_next),
      .pc          (pc),
      .out_valid   (out_valid),
      .taken       (taken)
`ifdef BRQ_STATS_EN
      ,
      .req_count   (req_count),
      .taken_count (taken_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive one cycle, push the expectation, then compare after the edge.
   task automatic apply(input string name, input logic r, input logic v,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ba, input logic [W-1:0] pn,
                        input bit use_tab, input exp_t tab);
      exp_t e;
      exp_t got;
      @(negedge clk);
      rst         = r;
      in_valid    = v;
      r2          = a;
      r3          = b;
      branch_addr = ba;
      pc_next     = pn;
      if (r) begin
         m_pc  = '0;
         m_tk  = 1'b0;
         m_req = 0;
         m_tkn = 0;
      end else if (v) begin
         m_tk  = (a == b);
         m_pc  = m_tk ? ba : pn;
         m_req = m_req + 1;
         if (m_tk) m_tkn = m_tkn + 1;
      end
      e.pc = m_pc;
      e.tk = m_tk;
      e.ov = !r && v;
      sb.push_back(use_tab ? tab : e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check({name, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         got = sb.pop_front();
         check({name, "_pc"},        32'(pc),        32'(got.pc));
         check({name, "_taken"},     32'(taken),     32'(got.tk));
         check({name, "_out_valid"}, 32'(out_valid), 32'(got.ov));
      end
   endtask

   vec_t vecs[14];
   exp_t none;

   initial begin
      logic [W-1:0] a, b, ba, pn;
      exp_t t;

      none = '{pc: '0, tk: 1'b0, ov: 1'b0};
      m_pc = '0; m_tk = 1'b0; m_req = 0; m_tkn = 0;
      rst = 1'b1; in_valid = 1'b0;
      r2 = '0; r3 = '0; branch_addr = '0; pc_next = '0;

      //         rst   v     r2         r3         ba         pn         pc         tk    ov
      vecs[0]  = '{1'b1, 1'b0, 19'd0,     19'd0,     19'd0,     19'd0,     19'd0,     1'b0, 1'b0};
      vecs[1]  = '{1'b1, 1'b1, 19'd4,     19'd4,     19'd9,     19'd8,     19'd0,     1'b0, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 19'd0,     19'd0,     19'd0,     19'd0,     19'd0,     1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 19'd2,     19'd2,     19'd150,   19'd200,   19'd150,   1'b1, 1'b1};
      vecs[4]  = '{1'b0, 1'b1, 19'd2,     19'd3,     19'd150,   19'd200,   19'd200,   1'b0, 1'b1};
      vecs[5]  = '{1'b0, 1'b1, 19'd5,     19'd5,     19'd300,   19'd400,   19'd300,   1'b1, 1'b1};
      vecs[6]  = '{1'b0, 1'b0, 19'd7,     19'd9,     19'd1,     19'd2,     19'd300,   1'b1, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 19'd1,     19'd1,     19'd5,     19'd6,     19'd300,   1'b1, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 19'h40000, 19'h00000, 19'd1234,  19'd4321,  19'd4321,  1'b0, 1'b1};
      vecs[9]  = '{1'b0, 1'b1, 19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 19'd0,     19'h7FFFF, 1'b1, 1'b1};
      vecs[10] = '{1'b0, 1'b1, 19'h3FFFF, 19'h7FFFF, 19'd10,    19'd20,    19'd20,    1'b0, 1'b1};
      vecs[11] = '{1'b1, 1'b1, 19'd6,     19'd6,     19'd99,    19'd98,    19'd0,     1'b0, 1'b0};
      vecs[12] = '{1'b0, 1'b1, 19'd1,     19'd1,     19'd77,    19'd88,    19'd77,    1'b1, 1'b1};
      vecs[13] = '{1'b0, 1'b1, 19'd1,     19'd0,     19'd0,     19'h7FFFF, 19'h7FFFF, 1'b0, 1'b1};

      for (int i = 0; i < 14; i++) begin
         t = '{pc: vecs[i].pc, tk: vecs[i].tk, ov: vecs[i].ov};
         apply($sformatf("vec%0d", i), vecs[i].rst, vecs[i].v, vecs[i].r2, vecs[i].r3,
               vecs[i].ba, vecs[i].pn, 1'b1, t);
      end

      // Random burst against the model, half the requests forced equal.
      for (int i = 0; i < 40; i++) begin
         a  = W'($urandom);
         b  = ($urandom_range(0, 1) == 1) ? a : W'($urandom);
         ba = W'($urandom);
         pn = W'($urandom);
         apply($sformatf("rnd%0d", i), 1'b0, ($urandom_range(0, 3) != 0), a, b, ba, pn, 1'b0, none);
      end

      // Reset with an equal-operand request pending, then 5 requests / 3 taken.
      apply("rst_req",  1'b1, 1'b1, 19'd3,  19'd3,  19'd500, 19'd600, 1'b0, none);
      apply("post_r1",  1'b0, 1'b1, 19'd10, 19'd10, 19'd11,  19'd12,  1'b0, none);
      apply("post_r2",  1'b0, 1'b1, 19'd10, 19'd20, 19'd21,  19'd22,  1'b0, none);
      apply("post_idle",1'b0, 1'b0, 19'd30, 19'd30, 19'd31,  19'd32,  1'b0, none);
      apply("post_r3",  1'b0, 1'b1, 19'd40, 19'd40, 19'd41,  19'd42,  1'b0, none);
      apply("post_r4",  1'b0, 1'b1, 19'd50, 19'd51, 19'd52,  19'd53,  1'b0, none);
      apply("post_r5",  1'b0, 1'b1, 19'd60, 19'd60, 19'd61,  19'd62,  1'b0, none);
      apply("post_idl2",1'b0, 1'b0, 19'd0,  19'd1,  19'd2,   19'd3,   1'b0, none);

`ifdef BRQ_STATS_EN
      check("req_count",   32'(req_count),   32'(m_req));
      check("taken_count", 32'(taken_count), 32'(m_tkn));
      check("req_count_5",   32'(req_count),   32'd5);
      check("taken_count_3", 32'(taken_count), 32'd3);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_brq_instruction
